param_memory: RTL

- Parametrised synchronous single-port memory: next generation of the fixed 32x8 memory used by the 8-bit CPU.
- Generalises data width, address width and depth.
- Adds a configurable read-latency pipeline with a read-valid strobe.
- Adds a hardware clear sequencer (automatic after reset and on request), a busy flag and an illegal-access error pulse.
- Serves as both program and data store in the CPU, behind the controller's read/write strobes.

---
 rtl/mem_pkg.sv | 14 +
 rtl/param_memory_rd_pipe.sv | 47 ++++
 rtl/param_memory.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and default parameters for param_memory
package mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_e;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 5;
   localparam int DEPTH_DEF  = 32;
   localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/param_memory_rd_pipe.sv
// rtl/param_memory_rd_pipe.sv - data+valid shift register between array read and data_out
module rd_pipe #(
   parameter int DATA_W = 8,
   parameter int STAGES = 0
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst_;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
   end else begin : g_pipe
      logic [STAGES-1:0] valid_q, valid_d;
      logic [DATA_W-1:0] data_q [STAGES];
      logic [DATA_W-1:0] data_d [STAGES];

      always_comb begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
         for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end

      always_ff @(posedge clk or negedge rst_) begin
         if (!rst_) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
         end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
         end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
   end

endmodule

// File: rtl/param_memory.sv
// rtl/param_memory.sv - single-port memory with read-latency pipeline, clear sequencer and error pulse
module param_memory
   import mem_pkg::*;
#(
   parameter int                DATA_W  = DATA_W_DEF,
   parameter int                ADDR_W  = ADDR_W_DEF,
   parameter int                DEPTH   = DEPTH_DEF,
   parameter int                RD_LAT  = 1,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              read,
   input  logic              write,
   input  logic              clear,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   // Latency outside 1..RD_LAT_MAX is clamped rather than producing a broken pipe.
   localparam int LAT_CLAMP = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
   localparam int PIPE_STAGES = LAT_CLAMP - 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rdv_q, rdv_d;

   logic              in_range, accept, rd_acc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_word;
   logic              pipe_valid;
   logic [DATA_W-1:0] pipe_data;

   always_comb begin
      in_range   = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
      accept     = (state_q == READY) && !clear && (read ^ write) && in_range;
      rd_acc     = accept && read;
      err_d      = (read || write) && !accept;
      rd_word    = in_range ? mem[addr] : '0;
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      mem_we     = 1'b0;
      mem_waddr  = addr;
      mem_wdata  = data_in;
      unique case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = CLR_VAL;
            if (clr_addr_q == LAST_ADDR) state_d = READY;
            else clr_addr_d = clr_addr_q + ADDR_W'(1);
         end
         READY: begin
            if (clear) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end else if (accept && write) begin
               mem_we = 1'b1;
            end
         end
      endcase
   end

   // No reset on the array: the clear sequencer initialises it after every reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   rd_pipe #(
      .DATA_W (DATA_W),
      .STAGES (PIPE_STAGES)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_      (rst_),
      .in_valid  (rd_acc),
      .in_data   (rd_word),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   always_comb begin
      rdv_d  = pipe_valid;
      dout_d = pipe_valid ? pipe_data : dout_q;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         err_q      <= 1'b0;
         dout_q     <= '0;
         rdv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         err_q      <= err_d;
         dout_q     <= dout_d;
         rdv_q      <= rdv_d;
      end
   end

   assign data_out = dout_q;
   assign rd_valid = rdv_q;
   assign busy     = (state_q == CLEAR);
   assign err      = err_q;

endmodule
